// File: rtl/gen_relojes_seq.sv
// Startup/shutdown sequencer for the 4f/2f/f clock-enable domains.
// Runs on clk8f and emits phase-aligned single-cycle enable strobes.
module gen_relojes_seq #(
    parameter int WARMUP_CYCLES = 8
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic       en4f,
    output logic       en2f,
    output logic       enf,
    output logic [2:0] phase,
    output logic       ready,
    output logic       busy,
    output logic       abort
);

    localparam int CW = $clog2(WARMUP_CYCLES);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        EN4,
        EN2,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] warm_cnt;

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= 3'd0;
            warm_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= 1'b0;
            phase <= phase + 3'd1;
            unique case (state)
                IDLE: begin
                    // phase holds 0 so WARMUP is entered at phase 0
                    phase    <= 3'd0;
                    warm_cnt <= '0;
                    if (start && !stop) state <= WARMUP;
                end
                WARMUP: begin
                    if (stop) begin
                        state <= IDLE;
                        phase <= 3'd0;
                        abort <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + CW'(1);
                        if (warm_cnt == WARM_LAST) state <= EN4;
                    end
                end
                EN4: begin
                    if (stop) begin
                        state <= IDLE;
                        phase <= 3'd0;
                        abort <= 1'b1;
                    end else if (phase == 3'd7) begin
                        state <= EN2;
                    end
                end
                EN2: begin
                    if (stop) begin
                        state <= IDLE;
                        phase <= 3'd0;
                        abort <= 1'b1;
                    end else if (phase == 3'd7) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    // the increment wraps phase back to 0 for IDLE
                    if (phase == 3'd7) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    phase <= 3'd0;
                end
            endcase
        end
    end

    logic st_en4, st_en2, st_run;

    assign st_run = (state == RUN) || (state == DRAIN);
    assign st_en2 = st_run || (state == EN2);
    assign st_en4 = st_en2 || (state == EN4);

    assign en4f  = st_en4 && phase[0];
    assign en2f  = st_en2 && (phase[1:0] == 2'd3);
    assign enf   = st_run && (phase == 3'd7);
    assign ready = (state == RUN);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_gen_relojes_seq.sv
// Self-checking bench for gen_relojes_seq: vector table, corner
// sequences and a randomized run against a cycle-count reference model.
module tb_gen_relojes_seq;

    localparam int W = 8;

    logic       clk8f = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       en4f, en2f, enf, ready, busy, abort;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    gen_relojes_seq #(.WARMUP_CYCLES(W)) dut (
        .clk8f(clk8f),
        .reset(rst),
        .start(start),
        .stop (stop),
        .en4f (en4f),
        .en2f (en2f),
        .enf  (enf),
        .phase(phase),
        .ready(ready),
        .busy (busy),
        .abort(abort)
    );

    always #5 clk8f = ~clk8f;

    // Reference model: t counts cycles since the sequence started
    // (1 = first WARMUP cycle); stage boundaries follow from W.
    bit m_act   = 1'b0;
    bit m_drain = 1'b0;
    bit m_abort = 1'b0;
    int m_t     = 0;

    function automatic int m_phase();
        return m_act ? (m_t - 1) % 8 : 0;
    endfunction

    function automatic logic [8:0] m_out();
        int  p;
        bit  s4, s2, sr;
        p  = m_phase();
        s4 = m_act && (m_t > W);
        s2 = m_act && (m_t > W + 8);
        sr = m_act && (m_t > W + 16);
        return {s4 && (p % 2 == 1), s2 && (p % 4 == 3), sr && (p == 7),
                sr && !m_drain, m_act, m_abort, 3'(p)};
    endfunction

    task automatic m_edge(bit r, bit s, bit p);
        bit old_abort;
        old_abort = m_abort;
        m_abort = 1'b0;
        if (r) begin
            m_act = 0; m_drain = 0; m_t = 0;
        end else if (!m_act) begin
            if (s && !p) begin
                m_act = 1; m_t = 1;
            end
        end else if (m_drain) begin
            if (m_phase() == 7) begin
                m_act = 0; m_drain = 0; m_t = 0;
            end else begin
                m_t++;
            end
        end else if (m_t <= W + 16) begin
            if (p) begin
                m_act = 0; m_t = 0; m_abort = 1;
            end else begin
                m_t++;
            end
        end else begin
            if (p) m_drain = 1;
            m_t++;
        end
        if (old_abort && m_abort) m_abort = 1;
    endtask

    function automatic logic [8:0] dut_out();
        return {en4f, en2f, enf, ready, busy, abort, phase};
    endfunction

    task automatic check(string nm, logic [8:0] got, logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic step(string nm);
        m_edge(rst, start, stop);
        @(posedge clk8f);
        #1;
        check(nm, dut_out(), m_out());
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic       p;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic r, logic s, logic p, int n,
                                logic [8:0] e);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.n = n; v.exp = e;
        return v;
    endfunction

    // exp = {en4f,en2f,enf, ready,busy,abort, phase}
    initial begin
        int n4, n2, n1, bad;
        bit ok;

        tbl[0]  = mk(1, 0, 0, 2,  9'b000_000_000);
        tbl[1]  = mk(0, 1, 1, 3,  9'b000_000_000);
        tbl[2]  = mk(0, 1, 0, 1,  9'b000_010_000);
        tbl[3]  = mk(0, 0, 0, 8,  9'b000_010_000);
        tbl[4]  = mk(0, 0, 0, 1,  9'b100_010_001);
        tbl[5]  = mk(0, 0, 0, 10, 9'b110_010_011);
        tbl[6]  = mk(0, 0, 0, 5,  9'b000_110_000);
        tbl[7]  = mk(0, 0, 0, 7,  9'b111_110_111);
        tbl[8]  = mk(0, 0, 0, 3,  9'b000_110_010);
        tbl[9]  = mk(0, 0, 1, 1,  9'b110_010_011);
        tbl[10] = mk(0, 0, 0, 4,  9'b111_010_111);
        tbl[11] = mk(0, 0, 0, 1,  9'b000_000_000);
        tbl[12] = mk(0, 1, 0, 1,  9'b000_010_000);
        tbl[13] = mk(0, 0, 0, 10, 9'b000_010_010);
        tbl[14] = mk(0, 0, 1, 1,  9'b000_001_000);
        tbl[15] = mk(0, 0, 0, 1,  9'b000_000_000);
        tbl[16] = mk(0, 1, 0, 1,  9'b000_010_000);
        tbl[17] = mk(0, 0, 0, 29, 9'b100_110_101);
        tbl[18] = mk(1, 0, 0, 1,  9'b000_000_000);
        tbl[19] = mk(0, 0, 0, 1,  9'b000_000_000);
        tbl[20] = mk(0, 1, 0, 1,  9'b000_010_000);
        tbl[21] = mk(0, 0, 0, 9,  9'b100_010_001);
        tbl[22] = mk(0, 0, 0, 22, 9'b111_110_111);
        tbl[23] = mk(0, 0, 1, 1,  9'b000_010_000);
        tbl[24] = mk(0, 0, 0, 7,  9'b111_010_111);
        tbl[25] = mk(0, 0, 0, 1,  9'b000_000_000);

        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].r; start = tbl[i].s; stop = tbl[i].p;
            for (int k = 0; k < tbl[i].n; k++) step("model_tbl");
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Steady-state RUN: strobe counts over 64 cycles
        rst = 0; stop = 0; start = 1;
        step("model_launch");
        start = 0;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step("model_wait");
            ok = ready;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        n4 = 0; n2 = 0; n1 = 0; bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (en4f) n4++;
            if (en2f) n2++;
            if (enf) n1++;
            if (enf && !(en2f && en4f && phase == 3'd7)) bad++;
            if (!ready) bad++;
            step("model_run");
        end
        check("cnt_en4f", 9'(n4), 9'd32);
        check("cnt_en2f", 9'(n2), 9'd16);
        check("cnt_enf", 9'(n1), 9'd8);
        check("coincide", 9'(bad), 9'd0);

        // stop with start held: drain, one IDLE cycle, relaunch
        stop = 1; start = 1;
        step("model_stop");
        stop = 0;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step("model_drain");
            ok = !busy;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout got=1 exp=0");
        end
        step("model_relaunch");
        check("relaunch", dut_out(), 9'b000_010_000);
        start = 0;

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            step("model_rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
